dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 256: number of 32-bit words stored.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data word width; only 32 is supported.
REQ-003 The block SHALL have parameter LATENCY, default 2: wait cycles between request acceptance and response, legal range 0..15.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-low (reset=0 resets on the next rising clk edge).
REQ-006 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: load data; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_error, output, 1 bit: the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, as a registered state decode with no combinational path from any input.
REQ-017 Acceptance SHALL occur when req_valid=1 and req_ready=1 on a rising edge; req_write, req_addr and req_wdata SHALL then be captured into internal registers.
REQ-018 On acceptance, the FSM SHALL move IDLE->WAIT and load the wait counter with LATENCY; with LATENCY=0 it SHALL move IDLE->RESP directly.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move WAIT->RESP on the edge where the counter equals 1.
REQ-020 On entry to RESP, the access SHALL execute: a store writes the memory word; a load registers that word into rsp_rdata.
REQ-021 Latency SHALL be exactly LATENCY+1 cycles from the acceptance edge to the first cycle with rsp_valid=1.
REQ-022 The word index SHALL be req_addr[31:2], and the request SHALL be an error if req_addr[1:0]!=0 or req_addr[31:2]>=MEMORY_DEPTH.
REQ-023 For an error request, memory SHALL be left unchanged, rsp_rdata SHALL be 0 and rsp_error SHALL be 1.
REQ-024 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_error SHALL be held stable until rsp_ready=1.
REQ-025 When rsp_valid=1 and rsp_ready=1, the FSM SHALL move RESP->IDLE and rsp_valid SHALL drop on the next cycle.
REQ-026 No request SHALL be accepted in the cycle of the response handshake, giving a maximum throughput of one request per LATENCY+2 cycles.
REQ-027 In WAIT or RESP, changes on req_* inputs SHALL be ignored, and a held req_valid SHALL be accepted only after return to IDLE.
REQ-028 A load that follows a completed store to the same address SHALL return the stored data.
REQ-029 rsp_ready asserted while rsp_valid=0 SHALL have no effect.

Reset
REQ-030 While reset=0 at a rising edge, the state SHALL become IDLE, and rsp_valid, rsp_error, rsp_rdata and the wait counter SHALL become 0.
REQ-031 One cycle after reset is released, req_ready SHALL be 1.
REQ-032 A reset asserted during WAIT SHALL abort the request, and a pending store SHALL NOT be written.
REQ-033 A reset asserted during RESP SHALL drop the response without a handshake.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-035 Package dmem_pkg SHALL hold the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the LATENCY counter width constant (4).
REQ-036 Sub-module dmem_array SHALL be the storage: synchronous write, registered read, MEMORY_DEPTH x 32; the FSM, counter and error check SHALL stay in dmem_responder.

Verification (LATENCY=2, MEMORY_DEPTH=256)
REQ-037 Store addr=0x10, wdata=0xDEADBEEF, then load addr=0x10 -> each rsp_valid appears 3 cycles after acceptance; the load returns rsp_rdata=0xDEADBEEF with rsp_error=0.
REQ-038 Load addr=0x12 (misaligned), then store addr=0x400 (index 256) -> rsp_error=1 and rsp_rdata=0 for both; a subsequent load of 0x400's aliased index 0 is unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles after a load of 0x10 -> rsp_valid stays 1 with rsp_rdata stable; req_ready=0 throughout; one handshake completes when rsp_ready=1.
REQ-040 Hold req_valid=1 continuously with 4 queued loads and rsp_ready=1 -> acceptances occur exactly 4 cycles apart, in order, with no request dropped or duplicated.
REQ-041 Accept a store of 0x5 to 0x20, then assert reset=0 during WAIT -> next cycle rsp_valid=0 and req_ready=0; after release req_ready=1, and a load of 0x20 returns the prior contents, not 0x5.
REQ-042 With LATENCY=0, a load of 0x10 -> rsp_valid=1 one cycle after acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, contents never reset.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait latency and
// alignment/range checking in front of a dmem_array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEMORY_DEPTH = 256,
  parameter int DATA_WIDTH   = 32,
  parameter int LATENCY      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  localparam int unsigned AW  = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    write_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    load_hit;

  logic                    accept;
  logic                    enter_resp;
  logic                    acc_write;
  logic                    acc_err;
  logic [31:0]             acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic                    mem_we;
  logic                    mem_re;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  // With LATENCY=0 the access happens on the acceptance edge itself, so the
  // live request fields are used instead of the captured copies.
  always_comb begin
    accept     = (state == IDLE) && req_valid && req_ready;
    acc_write  = (state == IDLE) ? req_write : write_q;
    acc_addr   = (state == IDLE) ? req_addr  : addr_q;
    acc_wdata  = (state == IDLE) ? req_wdata : wdata_q;
    acc_err    = addr_error(acc_addr, MEMORY_DEPTH);
    enter_resp = reset && ((accept && (LATENCY == 0)) ||
                           ((state == WAIT) && (cnt == CNT_W'(1))));
    mem_we     = enter_resp &&  acc_write && !acc_err;
    mem_re     = enter_resp && !acc_write && !acc_err;
    rsp_rdata  = load_hit ? arr_rdata : '0;
  end

  dmem_array #(
    .DEPTH (MEMORY_DEPTH),
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      load_hit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= LAT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            load_hit  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_error <= acc_err;
        load_hit  <= !acc_write && !acc_err;
      end
    end
  end

endmodule
